mutex_client_ctrl: RTL and testbench
====================================

// Module: mutex_client_ctrl
// PURPOSE
//   Synchronous front end for the two-port asynchronous mutex. Turns per-client
//   acquire/release requests into clean four-phase req/gnt handshakes on the mutex.
//   Synchronises the raw mutex grants into the clk domain and bounds how long a
//   client may hold the lock. Reports lock status, per-client grant counts and errors.
// PARAMETERS
//   SYNC_STAGES  2    flops per grant synchroniser (>=2)
//   HOLD_MAX     255  max cycles in HELD before forced release; 0 = no timeout
//   CNT_W        8    width of per-client grant counters
// PORTS
//   clk          in   1      system clock
//   rst          in   1      reset, asynchronous, active-high
//   acq_i        in   2      [k]=1: client k wants the lock (level)
//   rel_i        in   2      [k]=1: client k releases (sampled only in HELD)
//   tmo_clr_i    in   2      [k]=1: clear sticky timeout flag k
//   req_o        out  2      to mutex req1/req2 (bit0=req1), registered
//   gnt_i        in   2      from mutex gnt1/gnt2, asynchronous to clk
//   acquired_o   out  2      [k]=1: client k owns the lock
//   busy_o       out  2      [k]=1: client k FSM not IDLE
//   timeout_o    out  2      sticky: client k was force-released
//   excl_err_o   out  1      sticky: both synced grants seen high in same cycle
//   grant_cnt0_o out  CNT_W  count of grants to client 0, wraps
//   grant_cnt1_o out  CNT_W  count of grants to client 1, wraps
// BEHAVIOUR
//   - Reset (async): all FSMs IDLE; req_o, acquired_o, busy_o, timeout_o,
//     excl_err_o, counters, synchronisers = 0. req_o drops immediately, so a
//     held mutex is released by reset; no post-reset handshake is required.
//   - Per-client FSM, identical for k=0,1:
//     IDLE    : acq_i[k] -> REQ. rel_i ignored.
//     REQ     : req_o[k]=1; wait for gsync[k]=1 -> HELD; grant_cnt[k]++ (wraps).
//               acq_i dropping here does NOT abort: grant is taken, then released.
//     HELD    : req_o[k]=1, acquired_o[k]=1; hold_cnt from 0, +1 per cycle.
//               rel_i[k] -> RELEASE. Else if HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1
//               -> RELEASE and set timeout_o[k]. rel wins over timeout same cycle.
//     RELEASE : req_o[k]=0; wait for gsync[k]=0 -> IDLE. acq_i ignored until IDLE.
//   - busy_o[k]=1 in REQ/HELD/RELEASE. acquired_o is decoded from registered state.
//   - Latency (gnt rises combinationally after req_o): acquired_o rises
//     SYNC_STAGES+1 edges after req_o rises; IDLE->req_o high is 1 edge after acq_i.
//   - Re-acquire: minimum IDLE dwell is 1 cycle between successive handshakes.
//   - Contention: both in REQ; mutex grants one; loser stays in REQ until winner
//     reaches RELEASE and the mutex hands over; no starvation logic here.
//   - tmo_clr_i[k] clears timeout_o[k]; same-cycle set wins over clear.
//   - excl_err_o set if gsync==2'b11; never cleared except by rst. FSMs unaffected.
//   - hold_cnt width = max(1, $clog2(HOLD_MAX+1)); never overflows.
// STRUCTURE
//   - Shared package/header mutex_pkg: state encodings (IDLE=0, REQ=1, HELD=2,
//     RELEASE=3) and state width, shared with verification.
//   - Sub-module mutex_chan_fsm: one client's synchroniser, FSM, hold counter,
//     timeout flag and grant counter; instantiated twice. Top holds excl_err_o.
//   - Synchroniser flops carry no logic between stages.
// TESTING (bench models the async mutex behaviourally, gnt delay < 1 cycle)
//   1. acq_i=01 one cycle -> req_o=01 next edge; acquired_o[0]=1 3 edges later
//      (SYNC_STAGES=2); grant_cnt0_o=1.
//   2. Client 0 holds; acq_i[1]=1 -> client 1 stays REQ; rel_i[0] pulse ->
//      req_o[0]=0, then acquired_o[1]=1; acquired_o never 11.
//   3. HOLD_MAX=4, no rel -> acquired_o[0] high exactly 4 cycles, timeout_o[0]=1;
//      tmo_clr_i[0] -> 0. Repeat with rel_i on the last cycle -> no timeout.
//   4. rst during HELD -> req_o=00 and acquired_o=00 with no clock edge; after
//      release, acq_i=10 completes normally with grant_cnt1_o=1.
//   5. 256 acquire/release cycles with CNT_W=8 -> grant_cnt0_o wraps to 0.
//   6. Force gnt_i=11 for 3 cycles -> excl_err_o=1 and stays 1 until rst.

Source files
------------

// File: rtl/mutex_pkg.sv
// Shared definitions for the mutex client controller: per-client state encoding
// and the hold-counter width helper.
package mutex_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_HELD    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   // Counter width able to hold 0..hold_max, never narrower than one bit.
   function automatic int hold_width(input int hold_max);
      int w;
      w = $clog2(hold_max + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mutex_chan_fsm.sv
// One client channel: grant synchroniser, four-phase handshake FSM, hold timer,
// sticky timeout flag and wrapping grant counter.
module mutex_chan_fsm
   import mutex_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_MAX    = 255,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             acq,
   input  logic             rel,
   input  logic             tmo_clr,
   input  logic             gnt,
   output logic             req,
   output logic             acquired,
   output logic             busy,
   output logic             timeout,
   output logic             gsync,
   output logic [CNT_W-1:0] grant_cnt
);

   localparam int HOLD_W = hold_width(HOLD_MAX);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_r;
   state_t                 state_r;
   logic [HOLD_W-1:0]      hold_cnt_r;
   logic [CNT_W-1:0]       grant_cnt_r;
   logic                   req_r;
   logic                   acquired_r;
   logic                   busy_r;
   logic                   timeout_r;
   logic                   gsync_s;
   logic                   hold_hit_s;
   logic                   timeout_set_s;

   // Plain shift chain: the raw grant is asynchronous, so no logic between stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], gnt};
      end
   end

   assign gsync_s       = sync_r[SYNC_STAGES-1];
   assign hold_hit_s    = (HOLD_MAX != 0) && (hold_cnt_r == HOLD_LAST);
   assign timeout_set_s = (state_r == ST_HELD) && !rel && hold_hit_s;

   // Handshake FSM; outputs are registered alongside the state they decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         hold_cnt_r  <= {HOLD_W{1'b0}};
         grant_cnt_r <= {CNT_W{1'b0}};
         req_r       <= 1'b0;
         acquired_r  <= 1'b0;
         busy_r      <= 1'b0;
         timeout_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (acq) begin
                  state_r <= ST_REQ;
                  req_r   <= 1'b1;
                  busy_r  <= 1'b1;
               end
            end
            ST_REQ: begin
               if (gsync_s) begin
                  state_r     <= ST_HELD;
                  acquired_r  <= 1'b1;
                  hold_cnt_r  <= {HOLD_W{1'b0}};
                  grant_cnt_r <= grant_cnt_r + CNT_ONE;
               end
            end
            ST_HELD: begin
               if (rel || hold_hit_s) begin
                  state_r    <= ST_RELEASE;
                  req_r      <= 1'b0;
                  acquired_r <= 1'b0;
               end else if (hold_cnt_r != {HOLD_W{1'b1}}) begin
                  hold_cnt_r <= hold_cnt_r + HOLD_ONE;
               end
            end
            ST_RELEASE: begin
               if (!gsync_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               req_r      <= 1'b0;
               acquired_r <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase

         // A new timeout outranks a clear arriving in the same cycle.
         if (timeout_set_s) begin
            timeout_r <= 1'b1;
         end else if (tmo_clr) begin
            timeout_r <= 1'b0;
         end
      end
   end

   assign req       = req_r;
   assign acquired  = acquired_r;
   assign busy      = busy_r;
   assign timeout   = timeout_r;
   assign gsync     = gsync_s;
   assign grant_cnt = grant_cnt_r;

endmodule

// File: rtl/mutex_client_ctrl.sv
// Synchronous front end for a two-port asynchronous mutex: two client channels
// plus a sticky mutual-exclusion error detector on the synchronised grants.
module mutex_client_ctrl
   import mutex_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_MAX    = 255,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       acq_i,
   input  logic [1:0]       rel_i,
   input  logic [1:0]       tmo_clr_i,
   output logic [1:0]       req_o,
   input  logic [1:0]       gnt_i,
   output logic [1:0]       acquired_o,
   output logic [1:0]       busy_o,
   output logic [1:0]       timeout_o,
   output logic             excl_err_o,
   output logic [CNT_W-1:0] grant_cnt0_o,
   output logic [CNT_W-1:0] grant_cnt1_o
);

   logic [1:0] gsync_s;
   logic       excl_err_r;

   mutex_chan_fsm #(
      .SYNC_STAGES (SYNC_STAGES),
      .HOLD_MAX    (HOLD_MAX),
      .CNT_W       (CNT_W)
   ) u_chan0 (
      .clk       (clk),
      .rst       (rst),
      .acq       (acq_i[0]),
      .rel       (rel_i[0]),
      .tmo_clr   (tmo_clr_i[0]),
      .gnt       (gnt_i[0]),
      .req       (req_o[0]),
      .acquired  (acquired_o[0]),
      .busy      (busy_o[0]),
      .timeout   (timeout_o[0]),
      .gsync     (gsync_s[0]),
      .grant_cnt (grant_cnt0_o)
   );

   mutex_chan_fsm #(
      .SYNC_STAGES (SYNC_STAGES),
      .HOLD_MAX    (HOLD_MAX),
      .CNT_W       (CNT_W)
   ) u_chan1 (
      .clk       (clk),
      .rst       (rst),
      .acq       (acq_i[1]),
      .rel       (rel_i[1]),
      .tmo_clr   (tmo_clr_i[1]),
      .gnt       (gnt_i[1]),
      .req       (req_o[1]),
      .acquired  (acquired_o[1]),
      .busy      (busy_o[1]),
      .timeout   (timeout_o[1]),
      .gsync     (gsync_s[1]),
      .grant_cnt (grant_cnt1_o)
   );

   // Both grants high means the mutex broke exclusion; latched until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         excl_err_r <= 1'b0;
      end else if (gsync_s == 2'b11) begin
         excl_err_r <= 1'b1;
      end else begin
         excl_err_r <= excl_err_r;
      end
   end

   assign excl_err_o = excl_err_r;

endmodule

// File: tb/tb_mutex_client_ctrl.sv
// Directed bench for mutex_client_ctrl with a behavioural async mutex and a
// grant scoreboard checked whenever a client's acquired_o rises.
module tb_mutex_client_ctrl;

   typedef struct packed {
      logic       client;
      logic [7:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] acq_i;
   logic [1:0] rel_i;
   logic [1:0] tmo_clr_i;
   logic [1:0] req_o;
   logic [1:0] gnt_i;
   logic [1:0] acquired_o;
   logic [1:0] busy_o;
   logic [1:0] timeout_o;
   logic       excl_err_o;
   logic [7:0] grant_cnt0_o;
   logic [7:0] grant_cnt1_o;

   int         checks = 0;
   int         errors = 0;
   exp_t       sb[$];
   logic [7:0] exp_cnt [2];
   logic [1:0] prev_acq = 2'b00;
   logic       force_gnt = 1'b0;
   int         owner = 0;
   logic [1:0] gnt_m = 2'b00;

   mutex_client_ctrl #(
      .SYNC_STAGES (2),
      .HOLD_MAX    (4),
      .CNT_W       (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .acq_i        (acq_i),
      .rel_i        (rel_i),
      .tmo_clr_i    (tmo_clr_i),
      .req_o        (req_o),
      .gnt_i        (gnt_i),
      .acquired_o   (acquired_o),
      .busy_o       (busy_o),
      .timeout_o    (timeout_o),
      .excl_err_o   (excl_err_o),
      .grant_cnt0_o (grant_cnt0_o),
      .grant_cnt1_o (grant_cnt1_o)
   );

   always #5 clk = ~clk;

   // Behavioural mutex: the owner keeps the grant until its request drops.
   always @(req_o) begin
      if (owner == 1 && req_o[0] !== 1'b1) owner = 0;
      if (owner == 2 && req_o[1] !== 1'b1) owner = 0;
      if (owner == 0) begin
         if (req_o[0] === 1'b1) owner = 1;
         else if (req_o[1] === 1'b1) owner = 2;
      end
      gnt_m = {owner == 2, owner == 1};
   end

   assign gnt_i = force_gnt ? 2'b11 : gnt_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int k);
      exp_t e;
      exp_cnt[k] = exp_cnt[k] + 8'd1;
      e.client = k[0];
      e.cnt    = exp_cnt[k];
      sb.push_back(e);
   endtask

   // Advance one clock, sample 1 time unit after the edge, score new grants.
   task automatic tick();
      logic [1:0] rises;
      exp_t       e;
      @(posedge clk);
      #1;
      chk("never_both_acquired", {31'd0, acquired_o == 2'b11}, 32'd0);
      rises = acquired_o & ~prev_acq;
      prev_acq = acquired_o;
      for (int k = 0; k < 2; k++) begin
         if (rises[k]) begin
            checks++;
            assert (sb.size() > 0) else begin
               errors++;
               $error("FAIL sb_unexpected_grant observed=client%0d expected=none", k);
            end
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("sb_client", k, {31'd0, e.client});
               chk("sb_grant_cnt", (k == 0) ? {24'd0, grant_cnt0_o} : {24'd0, grant_cnt1_o},
                   {24'd0, e.cnt});
            end
         end
      end
   endtask

   task automatic wait_acq(input logic [1:0] mask);
      int n = 0;
      while (((acquired_o & mask) != mask) && n < 30) begin
         tick();
         n++;
      end
      chk("wait_acquired", {31'd0, n < 30}, 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_o != 2'b00 && n < 30) begin
         tick();
         n++;
      end
      chk("wait_idle", {31'd0, n < 30}, 32'd1);
   endtask

   task automatic reset_model();
      exp_cnt[0] = 8'd0;
      exp_cnt[1] = 8'd0;
   endtask

   initial begin
      int n;
      rst = 1'b1; acq_i = 2'b00; rel_i = 2'b00; tmo_clr_i = 2'b00;
      reset_model();
      tick(); tick();
      chk("rst_req", {30'd0, req_o}, 32'd0);
      chk("rst_acquired", {30'd0, acquired_o}, 32'd0);
      chk("rst_busy", {30'd0, busy_o}, 32'd0);
      chk("rst_timeout", {30'd0, timeout_o}, 32'd0);
      chk("rst_excl", {31'd0, excl_err_o}, 32'd0);
      chk("rst_cnts", {16'd0, grant_cnt1_o, grant_cnt0_o}, 32'd0);
      rst = 1'b0;

      // 1: single acquire, latency check
      acq_i = 2'b01; push(0);
      tick(); acq_i = 2'b00;
      chk("t1_req_edge1", {30'd0, req_o}, 32'd1);
      chk("t1_busy", {30'd0, busy_o}, 32'd1);
      chk("t1_acq_early", {30'd0, acquired_o}, 32'd0);
      tick(); tick();
      chk("t1_acq_edge3", {30'd0, acquired_o}, 32'd0);
      tick();
      chk("t1_acq_edge4", {30'd0, acquired_o}, 32'd1);
      chk("t1_cnt0", {24'd0, grant_cnt0_o}, 32'd1);
      rel_i = 2'b01; tick(); rel_i = 2'b00;
      chk("t1_rel_req", {30'd0, req_o}, 32'd0);
      chk("t1_rel_busy", {30'd0, busy_o}, 32'd1);
      wait_idle();

      // 2: contention, handover after release
      acq_i = 2'b01; push(0);
      tick(); acq_i = 2'b00;
      wait_acq(2'b01);
      acq_i = 2'b10; push(1);
      tick(); tick();
      chk("t2_both_req", {30'd0, req_o}, 32'd3);
      chk("t2_owner0", {30'd0, acquired_o}, 32'd1);
      chk("t2_busy", {30'd0, busy_o}, 32'd3);
      rel_i = 2'b01; tick(); rel_i = 2'b00; acq_i = 2'b00;
      chk("t2_req0_drop", {31'd0, req_o[0]}, 32'd0);
      wait_acq(2'b10);
      chk("t2_owner1", {30'd0, acquired_o}, 32'd2);
      chk("t2_cnt1", {24'd0, grant_cnt1_o}, 32'd1);
      chk("t2_no_timeout", {30'd0, timeout_o}, 32'd0);
      rel_i = 2'b10; tick(); rel_i = 2'b00;
      wait_idle();

      // 3: forced release after HOLD_MAX cycles
      acq_i = 2'b01; push(0);
      tick(); acq_i = 2'b00;
      wait_acq(2'b01);
      n = 0;
      while (acquired_o[0] && n < 20) begin
         n++;
         tick();
      end
      chk("t3_held_cycles", n, 32'd4);
      chk("t3_timeout_set", {30'd0, timeout_o}, 32'd1);
      tmo_clr_i = 2'b01; tick(); tmo_clr_i = 2'b00;
      chk("t3_timeout_clr", {30'd0, timeout_o}, 32'd0);
      wait_idle();
      // release on the final allowed cycle beats the timeout
      acq_i = 2'b01; push(0);
      tick(); acq_i = 2'b00;
      wait_acq(2'b01);
      tick(); tick(); tick();
      rel_i = 2'b01; tick(); rel_i = 2'b00;
      chk("t3_rel_last_acq", {30'd0, acquired_o}, 32'd0);
      chk("t3_rel_last_tmo", {30'd0, timeout_o}, 32'd0);
      wait_idle();
      // set outranks a simultaneous clear
      tmo_clr_i = 2'b01; acq_i = 2'b01; push(0);
      tick(); acq_i = 2'b00;
      wait_acq(2'b01);
      n = 0;
      while (acquired_o[0] && n < 20) begin
         n++;
         tick();
      end
      chk("t3_set_over_clr", {30'd0, timeout_o}, 32'd1);
      tmo_clr_i = 2'b00;
      wait_idle();

      // 4: async reset while HELD
      acq_i = 2'b01; push(0);
      tick(); acq_i = 2'b00;
      wait_acq(2'b01);
      #2 rst = 1'b1;
      #1;
      chk("t4_rst_req", {30'd0, req_o}, 32'd0);
      chk("t4_rst_acq", {30'd0, acquired_o}, 32'd0);
      chk("t4_rst_cnt0", {24'd0, grant_cnt0_o}, 32'd0);
      reset_model();
      tick(); tick();
      rst = 1'b0;
      acq_i = 2'b10; push(1);
      tick(); acq_i = 2'b00;
      wait_acq(2'b10);
      chk("t4_cnt1", {24'd0, grant_cnt1_o}, 32'd1);
      rel_i = 2'b10; tick(); rel_i = 2'b00;
      wait_idle();

      // 5: counter wrap after 256 grants
      for (int i = 0; i < 256; i++) begin
         acq_i = 2'b01; push(0);
         tick(); acq_i = 2'b00;
         wait_acq(2'b01);
         rel_i = 2'b01; tick(); rel_i = 2'b00;
         wait_idle();
      end
      chk("t5_cnt0_wrap", {24'd0, grant_cnt0_o}, 32'd0);

      // 6: both grants forced high
      force_gnt = 1'b1;
      tick(); tick(); tick();
      force_gnt = 1'b0;
      chk("t6_excl_set", {31'd0, excl_err_o}, 32'd1);
      repeat (5) tick();
      chk("t6_excl_sticky", {31'd0, excl_err_o}, 32'd1);
      chk("t6_fsm_idle", {30'd0, busy_o}, 32'd0);
      rst = 1'b1; tick(); rst = 1'b0;
      reset_model();
      chk("t6_excl_rst", {31'd0, excl_err_o}, 32'd0);
      chk("sb_drained", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
